// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the frame.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Wide enough to hold FIFO_DATA_WIDTH itself, not just the last index.
  function automatic int unsigned bit_cnt_width(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Baud divider for fifo_uart_tx: counts CLKS_PER_BIT enabled cycles and
// pulses bit_done on the last one; clear restarts the bit period.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end   = (cnt == CW'(CLKS_PER_BIT - 1));
  assign bit_done = clk_enable & ~clear & at_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clk_enable) begin
      if (clear || at_end) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a FIFO read port into asynchronous serial frames (start, data LSB
// first, optional even parity under FIFO_UART_TX_PARITY_EN, stop).
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DATA_WIDTH = 8,
  parameter int unsigned CLKS_PER_BIT    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_enable,
  input  logic                       fifo_empty,
  output logic                       fifo_read,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_read_data,
  output logic                       tx,
  output logic                       busy
);

  localparam int unsigned BCW = bit_cnt_width(FIFO_DATA_WIDTH);

  uart_state_e                state, state_d;
  logic [FIFO_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]             bit_cnt, bit_cnt_d;
  logic                       tx_d;
  logic                       bit_done;
  logic                       baud_clear;
  logic                       last_bit;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                       parity_q;
`endif

  assign fifo_read  = (state == IDLE) & ~fifo_empty & clk_enable;
  assign busy       = (state != IDLE) | fifo_read;
  assign last_bit   = (bit_cnt == BCW'(FIFO_DATA_WIDTH - 1));
  assign baud_clear = (state == IDLE) | (state == LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .clear     (baud_clear),
    .bit_done  (bit_done)
  );

  always_comb begin
    state_d   = state;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt;
    case (state)
      IDLE:  if (fifo_read) state_d = LOAD;
      LOAD:  if (clk_enable) begin
        state_d   = START;
        shift_d   = fifo_read_data;
        bit_cnt_d = '0;
      end
      START: if (bit_done) state_d = DATA;
      DATA:  if (bit_done) begin
        if (last_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      STOP:  if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so it changes with the state.
    tx_d = TX_IDLE_LEVEL;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = parity_q;
`endif
      default: tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      tx      <= TX_IDLE_LEVEL;
    end else if (clk_enable) begin
      state   <= state_d;
      shift_q <= shift_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           parity_q <= 1'b0;
    else if (clk_enable && state == LOAD) parity_q <= ^fifo_read_data;
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: behavioural FIFO, frame-timeline
// reference model, directed frames and randomized clk_enable/traffic.
module tb_fifo_uart_tx;

  localparam int W          = 8;
  localparam int CPB        = 4;
  localparam int FIFO_DEPTH = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
  localparam logic [10:0] EXP_A5 = 11'b10101001010;
  localparam logic [10:0] EXP_07 = 11'b11000001110;
  localparam logic [10:0] EXP_81 = 11'b10100000010;
  localparam logic [10:0] EXP_5A = 11'b10010110100;
`else
  localparam int PAR = 0;
  localparam logic [10:0] EXP_A5 = 11'b01101001010;
  localparam logic [10:0] EXP_07 = 11'b01000001110;
  localparam logic [10:0] EXP_81 = 11'b01100000010;
  localparam logic [10:0] EXP_5A = 11'b01010110100;
`endif
  localparam int NB        = W + 2 + PAR;
  localparam int FRAME_LEN = 2 + NB * CPB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clk_enable = 1'b1;
  logic         fifo_empty = 1'b1;
  logic         fifo_read;
  logic [W-1:0] fifo_read_data = '0;
  logic         tx;
  logic         busy;

  logic         wr_req = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] fq[$];
  int           fcount = 0;
  logic [W-1:0] exp_q[$];

  int           errors = 0;
  int           checks = 0;

  logic         m_active = 1'b0;
  int           m_pos = 0;
  logic [W-1:0] m_word = '0;
  logic         m_exp_rd;
  logic         stop_en = 1'b0;

  fifo_uart_tx #(
    .FIFO_DATA_WIDTH(W),
    .CLKS_PER_BIT   (CPB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .fifo_read_data(fifo_read_data),
    .tx            (tx),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Line level at enabled-cycle p of a frame, p=0 being the read cycle.
  function automatic logic tx_at(input logic [W-1:0] w, input int p);
    int k;
    if (p < 2) return 1'b1;
    k = (p - 2) / CPB;
    if (k == 0) return 1'b0;
    if (k <= W) return w[k-1];
    if (PAR != 0 && k == W + 1) return ^w;
    return 1'b1;
  endfunction

  // Behavioural FIFO: registered read data, flags updated on the edge.
  always @(posedge clk) begin
    if (wr_req) fq.push_back(wr_data);
    if (fifo_read && !reset && fq.size() > 0) fifo_read_data <= fq.pop_front();
    fcount     <= fq.size();
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      m_exp_rd = !m_active && clk_enable && !fifo_empty;
      if (m_exp_rd) begin
        chk("model_word_avail", exp_q.size(), exp_q.size() == 0 ? 1 : exp_q.size());
        if (exp_q.size() > 0) m_word = exp_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      chk("fifo_read", fifo_read, m_exp_rd);
      chk("busy", busy, m_active);
      chk("tx", tx, m_active ? tx_at(m_word, m_pos) : 1'b1);
      if (m_active && clk_enable) begin
        m_pos++;
        if (m_pos == FRAME_LEN) m_active = 1'b0;
      end
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (fcount >= FIFO_DEPTH && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) chk("push_timeout", t, 0);
    wr_data = w;
    wr_req  = 1'b1;
    exp_q.push_back(w);
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic wait_read(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!fifo_read && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_read_seen"}, fifo_read, 1);
  endtask

  task automatic send_frame(input string name, input logic [W-1:0] w,
                            input int stall_at, input int stall_len,
                            input logic [10:0] exp_bits, input int exp_len);
    logic        samp[300];
    logic        en_h[300];
    logic        comp[300];
    int          n, m, extra_reads;
    logic [10:0] got_bits;
    logic        held;
    push_word(w);
    wait_read(name);
    if (!fifo_read) return;
    samp[0] = tx; en_h[0] = 1'b1; n = 1; extra_reads = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      clk_enable = !(n >= stall_at && n < stall_at + stall_len);
      en_h[n] = clk_enable;
      @(negedge clk);
      if (fifo_read) extra_reads++;
      if (!busy) break;
      samp[n] = tx;
      n++;
    end
    if (!clk_enable) begin
      @(posedge clk); #1;
      clk_enable = 1'b1;
    end
    chk({name, "_len"}, n, exp_len);
    chk({name, "_extra_reads"}, extra_reads, 0);
    // Each disabled cycle leaves a duplicate sample on the following cycle.
    m = 0;
    for (int i = 0; i < n; i++)
      if (i == 0 || en_h[i-1]) begin
        comp[m] = samp[i];
        m++;
      end
    if (m >= FRAME_LEN) begin
      got_bits = '0;
      held = 1'b1;
      for (int b = 0; b < NB; b++) begin
        got_bits[b] = comp[2 + b * CPB];
        for (int j = 1; j < CPB; j++)
          if (comp[2 + b * CPB + j] !== got_bits[b]) held = 1'b0;
      end
      chk({name, "_pre_start_high"}, {comp[0], comp[1]}, 2'b11);
      chk({name, "_bits"}, got_bits, exp_bits);
      chk({name, "_bits_held"}, held, 1);
    end else begin
      chk({name, "_frame_short"}, m, FRAME_LEN);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int reads, last, bad_gap, viol, cyc, t;

    chk("model_pin_start", tx_at(8'hA5, 2), 0);
    chk("model_pin_bit0", tx_at(8'hA5, 2 + CPB), 1);
    chk("model_pin_stop", tx_at(8'hA5, FRAME_LEN - 1), 1);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_fifo_read", fifo_read, 0);

    reads = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_read || busy || !tx) reads++;
    end
    chk("idle_empty_activity", reads, 0);

    send_frame("a5", 8'hA5, 0, 0, EXP_A5, FRAME_LEN);
    send_frame("x07", 8'h07, 0, 0, EXP_07, FRAME_LEN);
    send_frame("stall", 8'h5A, 2 + 3 * CPB + 1, 7, EXP_5A, FRAME_LEN + 7);

    reads = 0; last = 0; bad_gap = 0; viol = 0; cyc = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) push_word(W'(i));
      end
      begin
        while (reads < 10 && cyc < 1000) begin
          @(negedge clk);
          cyc++;
          if (fifo_read) begin
            if (fifo_empty) viol++;
            if (reads > 0 && cyc - last != FRAME_LEN) bad_gap++;
            last = cyc;
            reads++;
          end
        end
      end
    join
    chk("burst_reads", reads, 10);
    chk("burst_gap", bad_gap, 0);
    chk("burst_read_when_empty", viol, 0);
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("burst_drained", busy, 0);

    push_word(8'h3C);
    wait_read("rst");
    repeat (2 + 4 * CPB + 1) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midframe_reset_tx", tx, 1);
    chk("midframe_reset_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("post_reset_busy", busy, 0);
    send_frame("after_reset", 8'h81, 0, 0, EXP_81, FRAME_LEN);

    stop_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 60)) @(posedge clk);
          push_word(W'($urandom));
        end
        stop_en = 1'b1;
      end
      begin
        while (!stop_en) begin
          @(posedge clk); #1;
          clk_enable = stop_en ? 1'b1 : ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        clk_enable = 1'b1;
      end
    join
    t = 0;
    @(negedge clk);
    while ((busy || !fifo_empty) && t < 10000) begin
      @(negedge clk);
      t++;
    end
    chk("random_drained", busy || !fifo_empty, 0);
    chk("random_model_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
